// File: rtl/pio_bus_pkg.sv
// Shared definitions for the SPI-to-PIO register bus bridge: frame geometry,
// FSM state encoding and default bus widths.
package pio_bus_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int HDR_BITS   = 16;
  localparam int FRAME_BITS = 48;
  localparam int W_BIT      = 15;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] HDR_LAST   = 6'd15;
  localparam logic [CNT_W-1:0] FRAME_LAST = 6'd47;
  localparam logic [CNT_W-1:0] FRAME_FULL = 6'd48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // A select that ends with a partial frame is malformed; 0 bits is a no-op.
  function automatic logic is_abort(input logic [CNT_W-1:0] cnt);
    return (cnt != 6'd0) && (cnt != FRAME_FULL);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Oversampling front end: synchronizes the SPI pins into clk and produces
// registered, mutually aligned edge pulses for sclk and cs_n.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic mosi_bit,
  output logic cs_n_sync,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] sclk_sr_r;
  logic [SYNC_STAGES-1:0] cs_sr_r;
  logic [SYNC_STAGES-1:0] mosi_sr_r;
  logic                   sclk_d_r;

  // Synchronizer chains plus one alignment stage that yields the edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr_r <= '0;
      cs_sr_r   <= '1;
      mosi_sr_r <= '0;
      sclk_d_r  <= 1'b0;
      mosi_bit  <= 1'b0;
      cs_n_sync <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_sr_r[0] <= sclk;
      cs_sr_r[0]   <= cs_n;
      mosi_sr_r[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sr_r[i] <= sclk_sr_r[i-1];
        cs_sr_r[i]   <= cs_sr_r[i-1];
        mosi_sr_r[i] <= mosi_sr_r[i-1];
      end
      sclk_d_r  <= sclk_sr_r[SYNC_STAGES-1];
      mosi_bit  <= mosi_sr_r[SYNC_STAGES-1];
      cs_n_sync <= cs_sr_r[SYNC_STAGES-1];
      sclk_rise <= sclk_sr_r[SYNC_STAGES-1] & ~sclk_d_r;
      sclk_fall <= ~sclk_sr_r[SYNC_STAGES-1] & sclk_d_r;
      cs_fall   <= cs_n_sync & ~cs_sr_r[SYNC_STAGES-1];
      cs_rise   <= ~cs_n_sync & cs_sr_r[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target that turns 48-bit host frames into single-cycle register
// writes and reads on the PIO control register bus.
module spi_reg_bridge
  import pio_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              write_en,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] data_out,
  output logic              frame_err
);

  logic mosi_bit_s, cs_n_sync_s, sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .mosi_bit  (mosi_bit_s),
    .cs_n_sync (cs_n_sync_s),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .cs_fall   (cs_fall_s),
    .cs_rise   (cs_rise_s)
  );

  state_t             state_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [DATA_W-1:0]  rx_r;
  logic [DATA_W-1:0]  tx_r;
  logic               hdr_w_r;
  logic [ADDR_W-1:0]  hdr_addr_r;
  logic               cap_r;

  logic [HDR_BITS-1:0] hdr_next_s;
  logic [DATA_W-1:0]   data_next_s;
  logic [ADDR_W-1:0]   addr_next_s;

  // Shift-register contents including the bit arriving on this rising edge.
  always_comb begin
    hdr_next_s  = {rx_r[HDR_BITS-2:0], mosi_bit_s};
    data_next_s = {rx_r[DATA_W-2:0], mosi_bit_s};
    addr_next_s = {hdr_next_s[ADDR_W-1:2], 2'b00};
  end

  // Frame FSM, bit counter, shift registers and bus-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= '0;
      rx_r       <= '0;
      tx_r       <= '0;
      hdr_w_r    <= 1'b0;
      hdr_addr_r <= '0;
      cap_r      <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      write_addr <= '0;
      data_in    <= '0;
      write_en   <= 1'b0;
      read_addr  <= '0;
      frame_err  <= 1'b0;
    end else begin
      write_en  <= 1'b0;
      frame_err <= 1'b0;
      cap_r     <= 1'b0;
      miso_oe   <= ~cs_n_sync_s;
      // read_addr settled last cycle, so data_out is valid for the capture
      if (cap_r) begin
        tx_r <= data_out;
      end
      if (cs_rise_s) begin
        state_r   <= IDLE;
        bit_cnt_r <= '0;
        miso      <= 1'b0;
        frame_err <= (state_r != IDLE) && is_abort(bit_cnt_r);
      end else begin
        case (state_r)
          IDLE: begin
            miso <= 1'b0;
            if (cs_fall_s) begin
              state_r   <= HDR;
              bit_cnt_r <= '0;
            end
          end
          HDR: begin
            miso <= 1'b0;
            if (sclk_rise_s) begin
              rx_r      <= data_next_s;
              bit_cnt_r <= bit_cnt_r + 6'd1;
              if (bit_cnt_r == HDR_LAST) begin
                state_r    <= DATA;
                hdr_w_r    <= hdr_next_s[W_BIT];
                hdr_addr_r <= addr_next_s;
                if (!hdr_next_s[W_BIT]) begin
                  read_addr <= addr_next_s;
                  cap_r     <= 1'b1;
                end
              end
            end
          end
          DATA: begin
            if (sclk_rise_s) begin
              rx_r      <= data_next_s;
              bit_cnt_r <= bit_cnt_r + 6'd1;
              if (bit_cnt_r == FRAME_LAST) begin
                state_r <= DONE;
                if (hdr_w_r) begin
                  write_en   <= 1'b1;
                  write_addr <= hdr_addr_r;
                  data_in    <= data_next_s;
                end
              end
            end
            if (sclk_fall_s) begin
              if (hdr_w_r) begin
                miso <= 1'b0;
              end else begin
                miso <= tx_r[DATA_W-1];
                tx_r <= {tx_r[DATA_W-2:0], 1'b0};
              end
            end
          end
          DONE: begin
            miso <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            miso    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: a word-array register model predicts
// bus writes, frame errors and MISO read data for random and directed frames.
module tb_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, write_en, frame_err;
  logic [9:0]  write_addr, read_addr;
  logic [31:0] data_in, data_out;

  spi_reg_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .write_addr (write_addr),
    .data_in    (data_in),
    .write_en   (write_en),
    .read_addr  (read_addr),
    .data_out   (data_out),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  logic [31:0] reg_file [256] = '{default: 32'h0};
  logic [31:0] ref_mem  [256] = '{default: 32'h0};

  assign data_out = reg_file[read_addr[9:2]];

  always @(posedge clk) begin
    if (write_en) reg_file[write_addr[9:2]] <= data_in;
  end

  typedef struct {
    logic        is_err;
    logic [9:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t bus_q[$];
  ev_t rd_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bus monitor: every strobe must match the oldest expected bus event.
  always @(negedge clk) begin
    if (!rst && (write_en || frame_err)) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_bus_event", {62'd0, write_en, frame_err}, 64'd0);
      end else begin
        ev_t e;
        e = bus_q.pop_front();
        if (e.is_err) begin
          chk("frame_err_pulse", {62'd0, write_en, frame_err}, 64'd1);
        end else begin
          chk("write_strobe", {62'd0, write_en, frame_err}, 64'd2);
          chk("write_addr", {54'd0, write_addr}, {54'd0, e.addr});
          chk("write_data", {32'd0, data_in}, {32'd0, e.data});
        end
      end
    end
  end

  int          nb = 0;
  logic [47:0] mi = 48'd0;
  logic [47:0] mo = 48'd0;

  // Frame monitor: collects MOSI/MISO at each sclk rise, judges at cs_n rise.
  always @(posedge sclk, posedge cs_n) begin
    if (cs_n) begin
      if (!rst && nb >= 48) begin
        if (mi[47]) begin
          chk("miso_zero_write", {16'd0, mo}, 64'd0);
        end else begin
          chk("miso_zero_hdr", {48'd0, mo[47:32]}, 64'd0);
          if (rd_q.size() == 0) begin
            chk("unexpected_read", 64'd1, 64'd0);
          end else begin
            ev_t e;
            e = rd_q.pop_front();
            chk("read_addr", {54'd0, read_addr}, {54'd0, e.addr});
            chk("read_miso", {32'd0, mo[31:0]}, {32'd0, e.data});
          end
        end
      end
      nb = 0;
    end else begin
      if (nb < 48) begin
        mi[47-nb] = mosi;
        mo[47-nb] = miso;
      end
      nb++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame of nbits clocks; rst_at >= 0 asserts reset at that bit.
  task automatic frame(input logic w, input logic [9:0] a, input logic [31:0] d,
                       input int nbits, input logic [4:0] rsv, input int rst_at);
    logic [47:0] f;
    f = {w, rsv, a, d};
    if (rst_at < 0) begin
      if (nbits > 0 && nbits < 48) begin
        bus_q.push_back('{1'b1, 10'h0, 32'h0});
      end else if (nbits >= 48) begin
        if (w) begin
          bus_q.push_back('{1'b0, {a[9:2], 2'b00}, d});
          ref_mem[a[9:2]] = d;
        end else begin
          rd_q.push_back('{1'b0, {a[9:2], 2'b00}, ref_mem[a[9:2]]});
        end
      end
    end
    cs_n = 1'b0;
    wait_clk(6);
    chk("miso_oe_active", {63'd0, miso_oe}, 64'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        break;
      end
      mosi = (i < 48) ? f[47-i] : 1'($urandom);
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(5);
    if (rst_at >= 0) begin
      chk("outputs_in_reset",
          {8'd0, write_en, write_addr, data_in, read_addr, miso, frame_err, miso_oe}, 64'd0);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(10);
    if (rst_at >= 0) rst = 1'b0;
    chk("miso_oe_idle", {62'd0, miso_oe, miso}, 64'd0);
    wait_clk(4);
  endtask

  initial begin
    wait_clk(5);
    chk("reset_state",
        {8'd0, write_en, write_addr, data_in, read_addr, miso, frame_err, miso_oe}, 64'd0);
    rst = 1'b0;
    wait_clk(5);

    frame(1'b1, 10'h0C8, 32'h0001_0000, 48, 5'd0, -1);
    frame(1'b1, 10'h0D4, 32'hA5A5_0003, 48, 5'd0, -1);
    frame(1'b0, 10'h0D4, 32'h0, 48, 5'd0, -1);
    frame(1'b1, 10'h038, 32'h1234_5678, 30, 5'd0, -1);
    frame(1'b1, 10'h038, 32'hCAFE_F00D, 48, 5'd0, -1);
    frame(1'b0, 10'h038, 32'h0, 48, 5'd0, -1);
    frame(1'b1, 10'h0CE, 32'hFFFF_FFFF, 48, 5'd0, -1);
    frame(1'b0, 10'h0CC, 32'h0, 48, 5'd0, -1);
    frame(1'b1, 10'h100, 32'h0BAD_BEEF, 50, 5'd0, -1);
    frame(1'b0, 10'h100, 32'h0, 48, 5'd0, -1);
    frame(1'b1, 10'h000, 32'h7777_0001, 48, 5'd0, -1);
    frame(1'b0, 10'h0D4, 32'h0, 48, 5'd0, 20);
    frame(1'b0, 10'h000, 32'h0, 48, 5'd0, -1);
    frame(1'b1, 10'h010, 32'h0, 0, 5'd0, -1);
    frame(1'b1, 10'h014, 32'h1, 5, 5'd0, -1);

    for (int k = 0; k < 24; k++) begin
      int r;
      int nbits;
      r = int'($urandom_range(0, 9));
      if (r == 0)      nbits = int'($urandom_range(1, 47));
      else if (r == 1) nbits = 48 + int'($urandom_range(1, 3));
      else             nbits = 48;
      frame(1'($urandom), 10'($urandom), $urandom, nbits, 5'($urandom), -1);
    end

    wait_clk(20);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    chk("read_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
